// File: rtl/sweep_peak_ctrl.sv
// Raster sweep of the H/V servo pulse widths with an ADC sample taken at every position.
// A position is flagged to the downstream max-hold register when its sample beats the stored maximum by more than HYST.
module sweep_peak_ctrl #(
  parameter int          ADC_W         = 12,
  parameter int unsigned PW_MIN        = 500,
  parameter int unsigned PW_MAX        = 2500,
  parameter int unsigned PW_STEP       = 100,
  parameter int unsigned SETTLE_CYCLES = 2000000,
  parameter int unsigned HYST          = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] LV,
  output logic             adc_req,
  output logic [ADC_W-1:0] PV,
  output logic             GT,
  output logic [31:0]      pulseWidth_H,
  output logic [31:0]      pulseWidth_V,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [31:0]     PW_MIN_W = 32'(PW_MIN);
  localparam logic [32:0]     PW_MAX_X = 33'(PW_MAX);
  localparam logic [32:0]     PW_STP_X = 33'(PW_STEP);
  localparam logic [ADC_W:0]  HYST_X   = (ADC_W+1)'(HYST);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_REQ, S_WAIT, S_CMP, S_STEP, S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [32:0]      h_next;
  logic [32:0]      v_next;
  logic             gt_next;

  // One extra bit on every add so neither the step nor LV+HYST can wrap.
  assign h_next  = {1'b0, pulseWidth_H} + PW_STP_X;
  assign v_next  = {1'b0, pulseWidth_V} + PW_STP_X;
  assign gt_next = {1'b0, adc_data} > ({1'b0, LV} + HYST_X);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous; it is only a high-priority branch inside the clocked block.
    if (RST) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      pulseWidth_H <= PW_MIN_W;
      pulseWidth_V <= PW_MIN_W;
      PV           <= '0;
      GT           <= 1'b0;
      adc_req      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pulseWidth_H <= PW_MIN_W;
            pulseWidth_V <= PW_MIN_W;
            settle_cnt   <= '0;
            busy         <= 1'b1;
            state        <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == CNT_LAST) begin
            settle_cnt <= '0;
            adc_req    <= 1'b1;
            state      <= S_REQ;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        S_REQ: begin
          adc_req <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // GT is registered from the same sample that lands in PV, so both appear together in CMP.
          if (adc_valid) begin
            PV    <= adc_data;
            GT    <= gt_next;
            state <= S_CMP;
          end
        end
        S_CMP: begin
          GT    <= 1'b0;
          state <= S_STEP;
        end
        S_STEP: begin
          if (h_next <= PW_MAX_X) begin
            pulseWidth_H <= h_next[31:0];
            state        <= S_SETTLE;
          end else if (v_next <= PW_MAX_X) begin
            pulseWidth_H <= PW_MIN_W;
            pulseWidth_V <= v_next[31:0];
            state        <= S_SETTLE;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_peak_ctrl.sv
// Directed bench for sweep_peak_ctrl: a queue of expected positions/flags is built per sweep and
// consumed as the DUT issues ADC requests. A second instance exercises a non-multiple PW_MAX.
module tb_sweep_peak_ctrl;

  localparam int PW_MAX_A = 700;
  localparam int PW_MAX_B = 750;

  typedef struct {
    int h;
    int v;
    int lv;
    int adc;
    bit gt;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        sel;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [11:0] LV;

  logic        req_a, gt_a, busy_a, done_a;
  logic        req_b, gt_b, busy_b, done_b;
  logic [11:0] pv_a, pv_b;
  logic [31:0] h_a, v_a, h_b, v_b;

  logic        obs_req, obs_gt, obs_busy, obs_done;
  logic [11:0] obs_pv;
  logic [31:0] obs_h, obs_v;

  int errors = 0;
  int checks = 0;
  int lv_tab[9];
  int adc_tab[9];

  always #5 CLK = ~CLK;

  sweep_peak_ctrl #(
    .ADC_W(12), .PW_MIN(500), .PW_MAX(PW_MAX_A), .PW_STEP(100), .SETTLE_CYCLES(4), .HYST(4)
  ) dut_a (
    .CLK(CLK), .RST(RST), .start(start & ~sel), .adc_data(adc_data), .adc_valid(adc_valid),
    .LV(LV), .adc_req(req_a), .PV(pv_a), .GT(gt_a), .pulseWidth_H(h_a), .pulseWidth_V(v_a),
    .busy(busy_a), .done(done_a)
  );

  sweep_peak_ctrl #(
    .ADC_W(12), .PW_MIN(500), .PW_MAX(PW_MAX_B), .PW_STEP(100), .SETTLE_CYCLES(4), .HYST(4)
  ) dut_b (
    .CLK(CLK), .RST(RST), .start(start & sel), .adc_data(adc_data), .adc_valid(adc_valid),
    .LV(LV), .adc_req(req_b), .PV(pv_b), .GT(gt_b), .pulseWidth_H(h_b), .pulseWidth_V(v_b),
    .busy(busy_b), .done(done_b)
  );

  assign obs_req  = sel ? req_b  : req_a;
  assign obs_gt   = sel ? gt_b   : gt_a;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_done = sel ? done_b : done_a;
  assign obs_pv   = sel ? pv_b   : pv_a;
  assign obs_h    = sel ? h_b    : h_a;
  assign obs_v    = sel ? v_b    : v_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_h"}, obs_h, 500);
    check({tag, "_v"}, obs_v, 500);
    check({tag, "_pv"}, obs_pv, 0);
    check({tag, "_gt"}, obs_gt, 0);
    check({tag, "_busy"}, obs_busy, 0);
    check({tag, "_done"}, obs_done, 0);
    check({tag, "_req"}, obs_req, 0);
  endtask

  // Runs one sweep on the selected instance. abort_at >= 0 resets the DUT while it waits
  // for the sample of that position index and ends the sweep there.
  task automatic sweep(input bit extra_start, input int abort_at);
    exp_t q[$];
    exp_t e;
    int   pmax;
    int   idx;
    int   seen;
    int   n_exp;
    int   extra;
    int   last;
    bit   got;
    pmax = sel ? PW_MAX_B : PW_MAX_A;
    idx  = 0;
    for (int v = 500; v <= pmax; v += 100) begin
      for (int h = 500; h <= pmax; h += 100) begin
        e.h   = h;
        e.v   = v;
        e.lv  = lv_tab[idx];
        e.adc = adc_tab[idx];
        e.gt  = (adc_tab[idx] > lv_tab[idx] + 4);
        q.push_back(e);
        last = h;
        idx++;
      end
    end
    n_exp = q.size();
    seen  = 0;
    extra = 0;

    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("busy_after_start", obs_busy, 1);
    if (extra_start) begin
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      check("busy_during_extra_start", obs_busy, 1);
    end

    while (q.size() > 0) begin
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        if (obs_req) got = 1'b1;
        else @(negedge CLK);
      end
      check("req_seen", got, 1);
      if (!got) return;
      e = q.pop_front();
      check("pos_h", obs_h, e.h);
      check("pos_v", obs_v, e.v);
      LV = 12'(e.lv);
      @(negedge CLK);
      check("req_one_cycle", obs_req, 0);
      if (seen == abort_at) begin
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_reset_values("abort");
        adc_valid = 1'b1;
        adc_data  = 12'd77;
        @(negedge CLK);
        adc_valid = 1'b0;
        check("abort_pv_held", obs_pv, 0);
        check("abort_no_gt", obs_gt, 0);
        check("abort_no_done", obs_done, 0);
        return;
      end
      seen++;
      adc_valid = 1'b1;
      adc_data  = 12'(e.adc);
      @(negedge CLK);
      adc_valid = 1'b0;
      check("cmp_gt", obs_gt, e.gt);
      check("cmp_pv", obs_pv, e.adc);
      check("cmp_no_done", obs_done, 0);
      @(negedge CLK);
      check("step_gt_low", obs_gt, 0);
      check("step_pv_stable", obs_pv, e.adc);
      check("step_h_stable", obs_h, e.h);
      check("step_v_stable", obs_v, e.v);
    end

    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (obs_done) got = 1'b1;
      else begin
        if (obs_req) extra++;
        @(negedge CLK);
      end
    end
    check("done_seen", got, 1);
    check("extra_req", extra, 0);
    check("positions", seen, n_exp);
    check("done_gt_low", obs_gt, 0);
    check("done_h_hold", obs_h, last);
    check("done_v_hold", obs_v, last);
    @(negedge CLK);
    check("done_one_cycle", obs_done, 0);
    check("idle_busy_low", obs_busy, 0);
  endtask

  initial begin
    RST       = 1'b1;
    start     = 1'b0;
    sel       = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    LV        = '0;
    repeat (2) @(negedge CLK);

    // T1: reset values on both instances.
    check_reset_values("reset_a");
    sel = 1'b1;
    check_reset_values("reset_b");
    sel = 1'b0;
    RST = 1'b0;
    @(negedge CLK);

    // T2: full sweep, every position beats LV=0.
    for (int i = 0; i < 9; i++) begin
      lv_tab[i]  = 0;
      adc_tab[i] = 10;
    end
    sweep(1'b0, -1);

    // T3: threshold boundaries, including the top of the ADC range.
    lv_tab  = '{50, 50, 4095, 4095, 0, 0, 4091, 4090, 100};
    adc_tab = '{54, 55, 4095, 0,    4, 5, 4095, 4095, 3};
    sweep(1'b0, -1);

    // T4: a second start while busy is ignored.
    for (int i = 0; i < 9; i++) begin
      lv_tab[i]  = 20;
      adc_tab[i] = 30 + i;
    end
    sweep(1'b1, -1);

    // T5: reset while waiting for the sample at (600,600).
    sweep(1'b0, 4);
    repeat (3) @(negedge CLK);
    check("post_abort_idle_busy", obs_busy, 0);

    // T6: PW_MAX not on the step grid.
    sel = 1'b1;
    for (int i = 0; i < 9; i++) begin
      lv_tab[i]  = 100;
      adc_tab[i] = (i % 2 == 0) ? 105 : 104;
    end
    sweep(1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
